// File: rtl/eth_echo_master.sv
// eth_echo_master
// ----------------------------------------------------------------------------
// APB requester that drives the ethernet register block on its own bus
// segment. It polls for received frames and copies each frame word by word
// from the RX buffer into the TX buffer. It then releases RX, launches the
// send and walks the TX ack handshake.
// Frames with size 0 or size above MTU are released without being sent.
//
// Ports
//   clk, rst        : system clock, synchronous active-high reset
//   enable          : engine starts a new poll only while high (sampled in IDLE)
//   m_psel .. m_pwdata : APB requester outputs
//   m_prdata, m_pready, m_pslverr : APB completer responses
//   busy            : high whenever the engine is not in IDLE
//   frames_echoed   : wrapping count of frames sent
//   frames_dropped  : wrapping count of frames released without sending
//   error           : sticky, set on pslverr or TX poll timeout
//   dbg_state       : current engine state, for observation only
//
// APB handshake: a transfer is one SETUP cycle (psel=1, penable=0) followed
// by ACCESS cycles (psel=1, penable=1) until pready=1. prdata and pslverr are
// taken on that pready cycle. paddr/pwrite/pwdata are registered at SETUP and
// held until then. The cycle after completion always has psel=0.
// ----------------------------------------------------------------------------
module eth_echo_master #(
  parameter logic [15:0] BASE         = 16'h0000,
  parameter int          MTU          = 1536,
  parameter int          POLL_GAP     = 64,
  parameter int          POLL_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        m_psel,
  output logic        m_penable,
  output logic        m_pwrite,
  output logic [15:0] m_paddr,
  output logic [31:0] m_pwdata,
  input  logic [31:0] m_prdata,
  input  logic        m_pready,
  input  logic        m_pslverr,
  output logic        busy,
  output logic [15:0] frames_echoed,
  output logic [15:0] frames_dropped,
  output logic        error,
  output logic [3:0]  dbg_state
);

  localparam logic [15:0] REG_BASE     = BASE + 16'(MTU);
  localparam logic [15:0] A_TXSIZE     = REG_BASE;
  localparam logic [15:0] A_RXREAD     = REG_BASE + 16'd4;
  localparam logic [15:0] A_SENDPACKET = REG_BASE + 16'd8;
  localparam logic [15:0] A_TXSTATE    = REG_BASE + 16'd12;
  localparam logic [15:0] A_RXSIZE     = REG_BASE + 16'd16;
  localparam logic [15:0] A_ACKTXIRQ   = REG_BASE + 16'd32;
  localparam logic [15:0] A_RXWRITE    = REG_BASE + 16'd36;
  localparam logic [15:0] MTU16        = 16'(MTU);
  // Loaded value of the gap down-counter; reaching zero ends the gap, so the
  // load is one less than the number of idle cycles wanted.
  localparam logic [15:0] GAP_INIT     = 16'(POLL_GAP - 1);
  localparam logic [16:0] TIMEOUT17    = 17'(POLL_TIMEOUT);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAITGAP,
    ST_POLLRX,
    ST_GETSIZE,
    ST_COPYRD,
    ST_COPYWR,
    ST_RELEASE,
    ST_SETSIZE,
    ST_SEND,
    ST_WAITTX2,
    ST_ACK1,
    ST_WAITTX3,
    ST_ACK0,
    ST_WAITTX0
  } state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_ACCESS
  } phase_t;

  state_t      r_state, w_state;
  phase_t      r_ph, w_ph;
  logic        r_pwrite, w_pwrite;
  logic [15:0] r_paddr, w_paddr;
  logic [31:0] r_pwdata, w_pwdata;
  logic [15:0] r_gap, w_gap;
  logic [15:0] r_polls, w_polls;
  logic [15:0] r_size, w_size;
  logic [15:0] r_nwords, w_nwords;
  logic [15:0] r_k, w_k;
  logic [31:0] r_word, w_word;
  logic        r_drop, w_drop;
  logic [15:0] r_echoed, w_echoed;
  logic [15:0] r_dropped, w_dropped;
  logic        r_error, w_error;

  // Request issued by the current state when its transfer is launched.
  logic [15:0] w_req_addr;
  logic        w_req_wr;
  logic [31:0] w_req_data;
  logic        w_is_xfer;
  logic        w_done;
  logic        w_poll_last;
  logic [15:0] w_data_addr;
  logic [15:0] w_k_inc;

  assign w_data_addr = BASE + {r_k[13:0], 2'b00};
  assign w_k_inc     = r_k + 16'd1;
  assign w_done      = (r_ph == PH_ACCESS) && m_pready;
  assign w_poll_last = (({1'b0, r_polls} + 17'd1) >= TIMEOUT17);
  assign w_is_xfer   = (r_state != ST_IDLE) && (r_state != ST_WAITGAP);

  always_comb begin
    w_req_addr = A_RXWRITE;
    w_req_wr   = 1'b0;
    w_req_data = 32'h0;
    case (r_state)
      ST_POLLRX:  w_req_addr = A_RXWRITE;
      ST_GETSIZE: w_req_addr = A_RXSIZE;
      ST_COPYRD:  w_req_addr = w_data_addr;
      ST_COPYWR: begin
        w_req_addr = w_data_addr;
        w_req_wr   = 1'b1;
        w_req_data = r_word;
      end
      ST_RELEASE: begin
        w_req_addr = A_RXREAD;
        w_req_wr   = 1'b1;
      end
      ST_SETSIZE: begin
        w_req_addr = A_TXSIZE;
        w_req_wr   = 1'b1;
        w_req_data = {16'h0, r_size};
      end
      ST_SEND: begin
        w_req_addr = A_SENDPACKET;
        w_req_wr   = 1'b1;
      end
      ST_WAITTX2, ST_WAITTX3, ST_WAITTX0: w_req_addr = A_TXSTATE;
      ST_ACK1: begin
        w_req_addr = A_ACKTXIRQ;
        w_req_wr   = 1'b1;
        w_req_data = 32'h1;
      end
      ST_ACK0: begin
        w_req_addr = A_ACKTXIRQ;
        w_req_wr   = 1'b1;
      end
      default: w_req_addr = A_RXWRITE;
    endcase
  end

  always_comb begin
    w_state   = r_state;
    w_ph      = r_ph;
    w_pwrite  = r_pwrite;
    w_paddr   = r_paddr;
    w_pwdata  = r_pwdata;
    w_gap     = r_gap;
    w_polls   = r_polls;
    w_size    = r_size;
    w_nwords  = r_nwords;
    w_k       = r_k;
    w_word    = r_word;
    w_drop    = r_drop;
    w_echoed  = r_echoed;
    w_dropped = r_dropped;
    w_error   = r_error;

    // Bus phase sequencing. A transfer state launches its transfer from an
    // idle bus phase once any pending poll gap has elapsed.
    case (r_ph)
      PH_IDLE: begin
        if (w_is_xfer) begin
          if (r_gap != 16'd0) begin
            w_gap = r_gap - 16'd1;
          end else begin
            w_ph     = PH_SETUP;
            w_paddr  = w_req_addr;
            w_pwrite = w_req_wr;
            w_pwdata = w_req_data;
          end
        end
      end
      PH_SETUP:  w_ph = PH_ACCESS;
      PH_ACCESS: if (m_pready) w_ph = PH_IDLE;
      default:   w_ph = PH_IDLE;
    endcase

    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_state = ST_WAITGAP;
          w_gap   = GAP_INIT;
        end
      end
      ST_WAITGAP: begin
        if (r_gap == 16'd0) w_state = ST_POLLRX;
        else                w_gap   = r_gap - 16'd1;
      end
      default: begin
        if (w_done) begin
          if (m_pslverr) begin
            w_error = 1'b1;
            w_state = ST_IDLE;
          end else begin
            case (r_state)
              ST_POLLRX: begin
                // Equal read/write pointers mean nothing is waiting.
                if (m_prdata[31:16] == m_prdata[15:0]) w_state = ST_IDLE;
                else                                   w_state = ST_GETSIZE;
              end
              ST_GETSIZE: begin
                w_size = m_prdata[15:0];
                if ((m_prdata[15:0] == 16'd0) || (m_prdata[15:0] > MTU16)) begin
                  w_drop  = 1'b1;
                  w_state = ST_RELEASE;
                end else begin
                  w_drop   = 1'b0;
                  w_nwords = 16'((17'(m_prdata[15:0]) + 17'd3) >> 2);
                  w_k      = 16'd0;
                  w_state  = ST_COPYRD;
                end
              end
              ST_COPYRD: begin
                w_word  = m_prdata;
                w_state = ST_COPYWR;
              end
              ST_COPYWR: begin
                w_k = w_k_inc;
                if (w_k_inc == r_nwords) w_state = ST_RELEASE;
                else                     w_state = ST_COPYRD;
              end
              ST_RELEASE: begin
                if (r_drop) begin
                  w_dropped = r_dropped + 16'd1;
                  w_state   = ST_IDLE;
                end else begin
                  w_state = ST_SETSIZE;
                end
              end
              ST_SETSIZE: w_state = ST_SEND;
              ST_SEND, ST_ACK1, ST_ACK0: begin
                // First poll of the following wait goes out without a gap.
                w_polls = 16'd0;
                w_gap   = 16'd0;
                case (r_state)
                  ST_SEND: w_state = ST_WAITTX2;
                  ST_ACK1: w_state = ST_WAITTX3;
                  default: w_state = ST_WAITTX0;
                endcase
              end
              ST_WAITTX2, ST_WAITTX3, ST_WAITTX0: begin
                if ((r_state == ST_WAITTX2) && (m_prdata == 32'd2)) begin
                  w_state = ST_ACK1;
                end else if ((r_state == ST_WAITTX3) && (m_prdata == 32'd3)) begin
                  w_state = ST_ACK0;
                end else if ((r_state == ST_WAITTX0) && (m_prdata == 32'd0)) begin
                  w_echoed = r_echoed + 16'd1;
                  w_state  = ST_IDLE;
                end else if (w_poll_last) begin
                  w_error = 1'b1;
                  w_state = ST_IDLE;
                end else begin
                  w_polls = r_polls + 16'd1;
                  w_gap   = GAP_INIT;
                end
              end
              default: w_state = ST_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ph      <= PH_IDLE;
      r_pwrite  <= 1'b0;
      r_paddr   <= 16'h0;
      r_pwdata  <= 32'h0;
      r_gap     <= 16'h0;
      r_polls   <= 16'h0;
      r_size    <= 16'h0;
      r_nwords  <= 16'h0;
      r_k       <= 16'h0;
      r_word    <= 32'h0;
      r_drop    <= 1'b0;
      r_echoed  <= 16'h0;
      r_dropped <= 16'h0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_ph      <= w_ph;
      r_pwrite  <= w_pwrite;
      r_paddr   <= w_paddr;
      r_pwdata  <= w_pwdata;
      r_gap     <= w_gap;
      r_polls   <= w_polls;
      r_size    <= w_size;
      r_nwords  <= w_nwords;
      r_k       <= w_k;
      r_word    <= w_word;
      r_drop    <= w_drop;
      r_echoed  <= w_echoed;
      r_dropped <= w_dropped;
      r_error   <= w_error;
    end
  end

  assign m_psel         = (r_ph != PH_IDLE);
  assign m_penable      = (r_ph == PH_ACCESS);
  assign m_pwrite       = r_pwrite;
  assign m_paddr        = r_paddr;
  assign m_pwdata       = r_pwdata;
  assign busy           = (r_state != ST_IDLE);
  assign frames_echoed  = r_echoed;
  assign frames_dropped = r_dropped;
  assign error          = r_error;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_eth_echo_master.sv
// Bench for eth_echo_master: an ethernet register block model answering on
// APB with random wait states, a transfer log compared against a frame-level
// reference, and bus protocol checks on every cycle.
module tb_eth_echo_master;

  localparam int          MTU = 1536;
  localparam int          G   = 8;
  localparam int          T   = 32;
  localparam logic [15:0] BASE = 16'h0000;
  localparam logic [15:0] R          = BASE + 16'(MTU);
  localparam logic [15:0] A_TXSIZE   = R;
  localparam logic [15:0] A_RXREAD   = R + 16'd4;
  localparam logic [15:0] A_SEND     = R + 16'd8;
  localparam logic [15:0] A_TXSTATE  = R + 16'd12;
  localparam logic [15:0] A_RXSIZE   = R + 16'd16;
  localparam logic [15:0] A_ACK      = R + 16'd32;
  localparam logic [15:0] A_RXWRITE  = R + 16'd36;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  always #5 clk = ~clk;

  logic        m_psel, m_penable, m_pwrite;
  logic [15:0] m_paddr;
  logic [31:0] m_pwdata;
  logic [31:0] m_prdata = 32'h0;
  logic        m_pready = 1'b0;
  logic        m_pslverr = 1'b0;
  logic        busy, error;
  logic [15:0] frames_echoed, frames_dropped;
  logic [3:0]  dbg_state;

  eth_echo_master #(.BASE(BASE), .MTU(MTU), .POLL_GAP(G), .POLL_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_prdata(m_prdata),
    .m_pready(m_pready), .m_pslverr(m_pslverr),
    .busy(busy), .frames_echoed(frames_echoed), .frames_dropped(frames_dropped),
    .error(error), .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ethernet block model
  logic [31:0] rx_mem [0:383];
  logic [31:0] tx_mem [0:383];
  logic [15:0] rx_size = 16'd0;
  bit          rx_pending = 1'b0;
  logic [31:0] tx_script[$];
  logic [31:0] tx_default = 32'h0;
  int          err_at = 0;
  int          data_rd_cnt = 0;
  int          idle_polls = 0;
  int          wait_left = 0;

  // scoreboard: {pwrite, paddr, pwdata-or-0}
  logic [48:0] obs_q[$];
  logic [48:0] exp_q[$];
  logic [15:0] exp_echoed = 16'd0;
  logic [15:0] exp_dropped = 16'd0;

  always @(negedge clk) begin
    logic [31:0] rd;
    bit err;
    if (m_psel && !m_penable) begin
      wait_left = $urandom_range(0, 5);
      m_pready  = 1'b0;
      m_pslverr = 1'b0;
    end else if (m_psel && m_penable) begin
      if (wait_left > 0) begin
        wait_left--;
        m_pready = 1'b0;
      end else begin
        rd = 32'h0;
        err = 1'b0;
        if (m_pwrite) begin
          if (m_paddr < R) tx_mem[m_paddr[10:2]] = m_pwdata;
          else if (m_paddr == A_RXREAD) rx_pending = 1'b0;
        end else begin
          if (m_paddr < R) begin
            data_rd_cnt++;
            rd = rx_mem[m_paddr[10:2]];
            if (data_rd_cnt == err_at) err = 1'b1;
          end else if (m_paddr == A_RXWRITE) begin
            rd = rx_pending ? 32'h0000_0001 : 32'h0003_0003;
          end else if (m_paddr == A_RXSIZE) begin
            rd = {16'h0, rx_size};
          end else if (m_paddr == A_TXSTATE) begin
            rd = (tx_script.size() > 0) ? tx_script.pop_front() : tx_default;
          end
        end
        m_prdata  = rd;
        m_pslverr = err;
        m_pready  = 1'b1;
        if (!m_pwrite && (m_paddr == A_RXWRITE) && (rd[31:16] == rd[15:0])) idle_polls++;
        else obs_q.push_back({m_pwrite, m_paddr, m_pwrite ? m_pwdata : 32'h0});
      end
    end else begin
      m_pready  = 1'b0;
      m_pslverr = 1'b0;
    end
  end

  // bus protocol checks
  logic        p_psel = 1'b0;
  logic        p_rst = 1'b1;
  logic [15:0] s_addr = 16'h0;
  logic        s_wr = 1'b0;
  logic [31:0] s_data = 32'h0;
  always @(negedge clk) begin
    if (!rst && !p_rst) begin
      if (m_penable) begin
        chk("penable_after_psel", p_psel, 1);
        chk("psel_in_access", m_psel, 1);
        chk("paddr_stable", m_paddr, s_addr);
        chk("pwrite_stable", m_pwrite, s_wr);
        chk("pwdata_stable", m_pwdata, s_data);
      end else if (m_psel) begin
        chk("idle_before_setup", p_psel, 0);
      end
    end
    if (m_psel && !m_penable) begin
      s_addr = m_paddr;
      s_wr   = m_pwrite;
      s_data = m_pwdata;
    end
    p_psel = m_psel;
    p_rst  = rst;
  end

  // reference model
  task automatic exp_rd(input logic [15:0] a);
    exp_q.push_back({1'b0, a, 32'h0});
  endtask

  task automatic exp_wr(input logic [15:0] a, input logic [31:0] d);
    exp_q.push_back({1'b1, a, d});
  endtask

  task automatic load_frame(input int size);
    for (int i = 0; i < 384; i++) rx_mem[i] = $urandom;
    rx_size = 16'(size);
    rx_pending = 1'b1;
    data_rd_cnt = 0;
  endtask

  // stuck=1: TXSTATE never reaches 2 and the wait must give up after T polls
  task automatic plan_frame(input int size, input bit stuck);
    int nw;
    int n;
    logic [31:0] tgt;
    exp_rd(A_RXWRITE);
    exp_rd(A_RXSIZE);
    if (size == 0 || size > MTU) begin
      exp_wr(A_RXREAD, 32'h0);
      exp_dropped++;
      return;
    end
    nw = (size + 3) / 4;
    for (int k = 0; k < nw; k++) begin
      exp_rd(BASE + 16'(4 * k));
      exp_wr(BASE + 16'(4 * k), rx_mem[k]);
    end
    exp_wr(A_RXREAD, 32'h0);
    exp_wr(A_TXSIZE, 32'(size));
    exp_wr(A_SEND, 32'h0);
    if (stuck) begin
      tx_default = 32'd1;
      for (int i = 0; i < T; i++) exp_rd(A_TXSTATE);
      return;
    end
    tx_default = 32'd0;
    for (int s = 0; s < 3; s++) begin
      tgt = (s == 0) ? 32'd2 : (s == 1) ? 32'd3 : 32'd0;
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) begin
        tx_script.push_back((tgt + 32'($urandom_range(1, 3))) % 32'd4);
        exp_rd(A_TXSTATE);
      end
      tx_script.push_back(tgt);
      exp_rd(A_TXSTATE);
      if (s == 0) exp_wr(A_ACK, 32'h1);
      if (s == 1) exp_wr(A_ACK, 32'h0);
    end
    exp_echoed++;
  endtask

  // Start the engine, then drop enable as soon as it leaves IDLE: the frame
  // it picks up must still run to the end.
  task automatic run_engine(input string tag);
    int n;
    enable = 1'b1;
    n = 0;
    while (!busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    enable = 1'b0;
    n = 0;
    while (busy && n < 40000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_finished"}, busy, 0);
  endtask

  task automatic compare_xfers(input string tag);
    chk({tag, "_xfer_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) chk({tag, "_xfer"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_echoed"}, frames_echoed, exp_echoed);
    chk({tag, "_dropped"}, frames_dropped, exp_dropped);
  endtask

  task automatic echo_frame(input string tag, input int size);
    load_frame(size);
    plan_frame(size, 1'b0);
    run_engine(tag);
    compare_xfers(tag);
    check_counters(tag);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_rx_released"}, rx_pending, 0);
  endtask

  initial begin
    int n;
    bit saw_hi, saw_lo;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_psel", m_psel, 0);
    chk("rst_penable", m_penable, 0);
    chk("rst_pwrite", m_pwrite, 0);
    chk("rst_paddr", m_paddr, 0);
    chk("rst_pwdata", m_pwdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_echoed", frames_echoed, 0);
    chk("rst_dropped", frames_dropped, 0);
    chk("rst_error", error, 0);

    // idle polling: only RXWRITE reads, roughly every POLL_GAP+4..+9 cycles
    rx_pending = 1'b0;
    idle_polls = 0;
    saw_hi = 1'b0;
    saw_lo = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy) saw_hi = 1'b1;
      else saw_lo = 1'b1;
    end
    enable = 1'b0;
    n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_finished", busy, 0);
    chk("idle_no_other_xfers", obs_q.size(), 0);
    chk("idle_polls_lo", idle_polls >= 400 / (G + 9) - 1, 1);
    chk("idle_polls_hi", idle_polls <= 400 / (G + 4) + 3, 1);
    chk("idle_busy_high", saw_hi, 1);
    chk("idle_busy_low", saw_lo, 1);
    check_counters("idle");
    obs_q.delete();

    echo_frame("echo60", 60);
    echo_frame("echo61", 61);
    echo_frame("echo1", 1);
    for (int i = 0; i < 3; i++) echo_frame("echo_rand", $urandom_range(2, 300));
    echo_frame("echo_mtu", MTU);

    load_frame(MTU + 1);
    plan_frame(MTU + 1, 1'b0);
    run_engine("oversize");
    compare_xfers("oversize");
    check_counters("oversize");

    load_frame(0);
    plan_frame(0, 1'b0);
    run_engine("size0");
    compare_xfers("size0");
    check_counters("size0");

    // pslverr on the third data read
    load_frame(60);
    err_at = 3;
    exp_rd(A_RXWRITE);
    exp_rd(A_RXSIZE);
    exp_rd(BASE);
    exp_wr(BASE, rx_mem[0]);
    exp_rd(BASE + 16'd4);
    exp_wr(BASE + 16'd4, rx_mem[1]);
    exp_rd(BASE + 16'd8);
    run_engine("slverr");
    compare_xfers("slverr");
    chk("slverr_error", error, 1);
    chk("slverr_psel", m_psel, 0);
    check_counters("slverr");
    err_at = 0;
    rx_pending = 1'b0;

    // synchronous reset while a data read is in SETUP
    load_frame(60);
    enable = 1'b1;
    n = 0;
    while (!(m_psel && !m_penable && !m_pwrite && (m_paddr < R) && data_rd_cnt == 2) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reached_copy", n < 5000, 1);
    rst = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    chk("rst_mid_psel", m_psel, 0);
    chk("rst_mid_penable", m_penable, 0);
    chk("rst_mid_pwrite", m_pwrite, 0);
    chk("rst_mid_paddr", m_paddr, 0);
    chk("rst_mid_pwdata", m_pwdata, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_error", error, 0);
    chk("rst_mid_echoed", frames_echoed, 0);
    chk("rst_mid_dropped", frames_dropped, 0);
    rst = 1'b0;
    exp_echoed = 16'd0;
    exp_dropped = 16'd0;
    rx_pending = 1'b0;
    obs_q.delete();
    tx_script.delete();
    @(negedge clk);

    // TXSTATE stuck at 1: exactly T polls, then error
    load_frame(20);
    plan_frame(20, 1'b1);
    run_engine("stuck");
    compare_xfers("stuck");
    chk("stuck_error", error, 1);
    check_counters("stuck");
    tx_default = 32'd0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: bench did not reach its end (compared=%0d)", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
